// File: rtl/vision_pkg.sv
// Shared widths, frame defaults and types for the vision pipeline blocks.
// No ports: imported by hsv_threshold and hsv_color_bbox.
package vision_pkg;

    localparam int unsigned IMG_W_DEF = 640;
    localparam int unsigned IMG_H_DEF = 480;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned CNT_W     = 19;
    localparam int unsigned H_W       = 9;
    localparam int unsigned C_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    // Running bounding box and match count for the frame in progress.
    typedef struct packed {
        logic [X_W-1:0]   x_min;
        logic [X_W-1:0]   x_max;
        logic [Y_W-1:0]   y_min;
        logic [Y_W-1:0]   y_max;
        logic [CNT_W-1:0] cnt;
    } bbox_acc_t;

endpackage

// File: rtl/hsv_threshold.sv
// Combinational HSV window classifier; one instance per colour of interest.
// Ports: hsv_h/hsv_s/hsv_v pixel in, match_c combinational match flag out.
module hsv_threshold
    import vision_pkg::*;
#(
    parameter logic [H_W-1:0] H_MIN = 9'd20,
    parameter logic [H_W-1:0] H_MAX = 9'd40,
    parameter logic [C_W-1:0] S_MIN = 8'd80,
    parameter logic [C_W-1:0] V_MIN = 8'd60
) (
    input  logic [H_W-1:0] hsv_h,
    input  logic [C_W-1:0] hsv_s,
    input  logic [C_W-1:0] hsv_v,
    output logic           match_c
);

    logic [H_W-1:0] h_norm;
    logic           hue_ok;

    // Hue 360 is the same angle as 0; H_MIN > H_MAX means the window wraps through 0.
    always_comb begin
        h_norm = (hsv_h >= 9'd360) ? '0 : hsv_h;
        if (H_MIN <= H_MAX) begin
            hue_ok = (h_norm >= H_MIN) && (h_norm <= H_MAX);
        end else begin
            hue_ok = (h_norm >= H_MIN) || (h_norm <= H_MAX);
        end
        match_c = hue_ok && (hsv_s >= S_MIN) && (hsv_v >= V_MIN);
    end

endmodule

// File: rtl/hsv_color_bbox.sv
// Per-frame colour blob tracker: classifies HSV pixels, tracks x/y position and
// publishes bounding box + match count once per frame.
// Ports: clk, rst (async active-low); in_valid/in_sof/in_eol/in_eof + hsv_h/s/v
// pixel stream in; pix_match/pix_match_valid per-pixel overlay flag out;
// bbox_valid pulse with bbox_found, bbox_x/y_min/max, bbox_count frame result out.
module hsv_color_bbox
    import vision_pkg::*;
#(
    parameter int unsigned    IMG_W      = IMG_W_DEF,
    parameter int unsigned    IMG_H      = IMG_H_DEF,
    parameter logic [H_W-1:0] H_MIN      = 9'd20,
    parameter logic [H_W-1:0] H_MAX      = 9'd40,
    parameter logic [C_W-1:0] S_MIN      = 8'd80,
    parameter logic [C_W-1:0] V_MIN      = 8'd60,
    parameter int unsigned    MIN_PIXELS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic             in_eof,
    input  logic [H_W-1:0]   hsv_h,
    input  logic [C_W-1:0]   hsv_s,
    input  logic [C_W-1:0]   hsv_v,
    output logic             pix_match,
    output logic             pix_match_valid,
    output logic             bbox_valid,
    output logic             bbox_found,
    output logic [X_W-1:0]   bbox_x_min,
    output logic [X_W-1:0]   bbox_x_max,
    output logic [Y_W-1:0]   bbox_y_min,
    output logic [Y_W-1:0]   bbox_y_max,
    output logic [CNT_W-1:0] bbox_count
);

    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
    localparam bbox_acc_t        ACC_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0, cnt: '0};

    state_t         state, state_nxt;
    logic [X_W-1:0] x_cnt, pos_x;
    logic [Y_W-1:0] y_cnt, pos_y;
    bbox_acc_t      acc, acc_base, acc_nxt;
    logic           match_c, accept_c, publish_c;

    hsv_threshold #(
        .H_MIN (H_MIN),
        .H_MAX (H_MAX),
        .S_MIN (S_MIN),
        .V_MIN (V_MIN)
    ) u_thr (
        .hsv_h   (hsv_h),
        .hsv_s   (hsv_s),
        .hsv_v   (hsv_v),
        .match_c (match_c)
    );

    // Position of the current beat; sof pins it to the frame origin.
    always_comb begin
        pos_x = in_sof ? '0 : x_cnt;
        pos_y = in_sof ? '0 : y_cnt;
    end

    // Position counters for the next beat, saturating so a lost eol/eof never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_valid) begin
            if (in_eol) begin
                x_cnt <= '0;
                y_cnt <= (pos_y == Y_LAST) ? pos_y : pos_y + Y_W'(1);
            end else begin
                x_cnt <= (pos_x == X_LAST) ? pos_x : pos_x + X_W'(1);
                y_cnt <= pos_y;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state; a sof during PUBLISH is the first beat of the next frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid && in_sof) state_nxt = in_eof ? PUBLISH : ACTIVE;
            end
            ACTIVE: begin
                if (in_valid && in_eof) state_nxt = PUBLISH;
            end
            PUBLISH: begin
                if (in_valid && in_sof) state_nxt = in_eof ? PUBLISH : ACTIVE;
                else                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat acceptance: sof always opens a frame (dropping any partial one).
    always_comb begin
        accept_c  = in_valid && (in_sof || (state == ACTIVE));
        publish_c = accept_c && in_eof;
    end

    // Accumulator update including the current pixel.
    always_comb begin
        acc_base = in_sof ? ACC_INIT : acc;
        acc_nxt  = acc_base;
        if (match_c) begin
            if (pos_x < acc_base.x_min) acc_nxt.x_min = pos_x;
            if (pos_x > acc_base.x_max) acc_nxt.x_max = pos_x;
            if (pos_y < acc_base.y_min) acc_nxt.y_min = pos_y;
            if (pos_y > acc_base.y_max) acc_nxt.y_max = pos_y;
            if (acc_base.cnt != '1)     acc_nxt.cnt   = acc_base.cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          acc <= ACC_INIT;
        else if (accept_c) acc <= acc_nxt;
    end

    // Registered outputs; the frame result is captured on the eof beat so it
    // is presented together with the bbox_valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_match       <= 1'b0;
            pix_match_valid <= 1'b0;
            bbox_valid      <= 1'b0;
            bbox_found      <= 1'b0;
            bbox_x_min      <= '0;
            bbox_x_max      <= '0;
            bbox_y_min      <= '0;
            bbox_y_max      <= '0;
            bbox_count      <= '0;
        end else begin
            pix_match       <= in_valid && match_c;
            pix_match_valid <= in_valid;
            bbox_valid      <= publish_c;
            if (publish_c) begin
                bbox_found <= (acc_nxt.cnt >= MIN_CNT);
                bbox_count <= acc_nxt.cnt;
                if (acc_nxt.cnt == '0) begin
                    bbox_x_min <= '0;
                    bbox_x_max <= '0;
                    bbox_y_min <= '0;
                    bbox_y_max <= '0;
                end else begin
                    bbox_x_min <= acc_nxt.x_min;
                    bbox_x_max <= acc_nxt.x_max;
                    bbox_y_min <= acc_nxt.y_min;
                    bbox_y_max <= acc_nxt.y_max;
                end
            end
        end
    end

endmodule
